data_mem_responder: RTL and testbench

- Word-addressed data-memory responder that serves the CPU's load/store strobes (mem_read/mem_write) with a configurable wait-state latency and a one-cycle ready pulse.
- Sits on the memory side of the CPU data port; the CPU stalls until ready is seen.
- Internal register-array storage, word-aligned accesses only, error flag for illegal requests.

---
 rtl/data_mem_if.sv | 22 ++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// CPU data-port bus between a load/store requester and the data-memory responder.
// The requester holds its strobes until ready and drops them after the ready cycle.
interface data_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering CPU load/store strobes after a fixed
// number of wait states, with a one-cycle ready pulse and an illegal-request flag.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    data_mem_if.slave bus
);
    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam int         AW        = DEPTH_LOG2 + 2;
    localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic                  op_read_r;
    logic                  op_write_r;
    logic [AW-1:0]         addr_r;
    logic [31:0]           wdata_r;
    logic [31:0]           rdata_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  err_r;
    logic [31:0]           mem [0:WORDS-1];

    logic                  accept_s;
    logic                  enter_resp_s;
    logic                  cur_read_s;
    logic                  cur_write_s;
    logic [AW-1:0]         cur_addr_s;
    logic [31:0]           cur_wdata_s;
    logic                  illegal_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  mem_we_s;
    logic                  load_s;
    logic                  unused_hi_s;

    // High address bits are deliberately dropped so accesses alias modulo the array size
    assign unused_hi_s = ^bus.addr[31:AW];

    // Select the live request in IDLE (zero-wait path) or the latched one afterwards
    always_comb begin
        accept_s = (state_r == IDLE) && (bus.mem_read || bus.mem_write);
        if (state_r == IDLE) begin
            cur_read_s  = bus.mem_read;
            cur_write_s = bus.mem_write;
            cur_addr_s  = bus.addr[AW-1:0];
            cur_wdata_s = bus.wdata;
        end else begin
            cur_read_s  = op_read_r;
            cur_write_s = op_write_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
        case (state_r)
            IDLE:    enter_resp_s = accept_s && ZERO_WAIT;
            WAIT:    enter_resp_s = (cnt_r == 4'd0);
            default: enter_resp_s = 1'b0;
        endcase
        illegal_s = (cur_read_s && cur_write_s) || (cur_addr_s[1:0] != 2'b00);
        idx_s     = cur_addr_s[AW-1:2];
        mem_we_s  = enter_resp_s && cur_write_s && !illegal_s && !rst;
        load_s    = enter_resp_s && cur_read_s && !illegal_s;
    end

    // Storage array; not reset, written only on the edge entering RESP
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[idx_s] <= cur_wdata_s;
        end
    end

    // Request FSM and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            op_read_r  <= 1'b0;
            op_write_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            rdata_r    <= 32'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            ready_r <= enter_resp_s;
            err_r   <= enter_resp_s && illegal_s;
            if (load_s) begin
                rdata_r <= mem[idx_s];
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_read_r  <= bus.mem_read;
                        op_write_r <= bus.mem_write;
                        addr_r     <= bus.addr[AW-1:0];
                        wdata_r    <= bus.wdata;
                        busy_r     <= 1'b1;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance,
// directed scenarios plus randomized loads/stores against a word-array model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_if bus0 ();
    data_mem_if bus1 ();

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        rd_v [2];
    logic        wr_v [2];
    logic [31:0] ad_v [2];
    logic [31:0] wd_v [2];
    logic [31:0] rdata_o [2];
    logic        ready_o [2];
    logic        busy_o [2];
    logic        err_o [2];

    assign bus0.mem_read  = rd_v[0];
    assign bus0.mem_write = wr_v[0];
    assign bus0.addr      = ad_v[0];
    assign bus0.wdata     = wd_v[0];
    assign bus1.mem_read  = rd_v[1];
    assign bus1.mem_write = wr_v[1];
    assign bus1.addr      = ad_v[1];
    assign bus1.wdata     = wd_v[1];
    assign rdata_o[0] = bus0.rdata;
    assign ready_o[0] = bus0.ready;
    assign busy_o[0]  = bus0.busy;
    assign err_o[0]   = bus0.err;
    assign rdata_o[1] = bus1.rdata;
    assign ready_o[1] = bus1.ready;
    assign busy_o[1]  = bus1.busy;
    assign err_o[1]   = bus1.err;

    // Reference model: word array per instance plus the last load result
    logic [31:0] model_mem [2][256];
    logic [31:0] exp_rdata [2];
    int          latency [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_req(input int s, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit scramble);
        int          cyc;
        bit          legal;
        logic [7:0]  idx;
        legal = !(rd && wr) && (a[1:0] == 2'b00);
        idx   = a[9:2];
        @(negedge clk);
        check("idle_busy", 32'(busy_o[s]), 32'd0);
        rd_v[s] = rd; wr_v[s] = wr; ad_v[s] = a; wd_v[s] = d;
        @(posedge clk); #1;
        cyc = 1;
        while (ready_o[s] !== 1'b1 && cyc < 20) begin
            check("wait_busy", 32'(busy_o[s]), 32'd1);
            if (scramble) begin
                ad_v[s] = $urandom;
                wd_v[s] = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (legal && wr) model_mem[s][idx] = d;
        if (legal && rd) exp_rdata[s] = model_mem[s][idx];
        check("latency", 32'(cyc), 32'(latency[s]));
        check("resp_busy", 32'(busy_o[s]), 32'd1);
        check("err", 32'(err_o[s]), 32'(!legal));
        check("rdata", rdata_o[s], exp_rdata[s]);
        rd_v[s] = 1'b0; wr_v[s] = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", 32'(ready_o[s]), 32'd0);
        check("busy_clear", 32'(busy_o[s]), 32'd0);
        check("err_quiet", 32'(err_o[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int op;
        logic [31:0] a;
        latency[0] = 3;
        latency[1] = 1;
        for (int i = 0; i < 2; i++) begin
            rd_v[i] = 1'b0; wr_v[i] = 1'b0; ad_v[i] = 32'd0; wd_v[i] = 32'd0;
            exp_rdata[i] = 32'd0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready_o[i]), 32'd0);
            check("rst_busy", 32'(busy_o[i]), 32'd0);
            check("rst_err", 32'(err_o[i]), 32'd0);
            check("rst_rdata", rdata_o[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_spurious_ready", 32'(ready_o[0]), 32'd0);
        end

        // Give both instances known contents in words 0..15
        for (int s2 = 0; s2 < 2; s2++)
            for (int w = 0; w < 16; w++)
                do_req(s2, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);

        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("rdata_hold", rdata_o[0], 32'hDEADBEEF);
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0);
        do_req(0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        check("both_strobe_old", rdata_o[0], 32'h0BADF00D);
        do_req(0, 1'b0, 1'b1, 32'h400, 32'h12345678, 1'b1);
        do_req(0, 1'b1, 1'b0, 32'h000, 32'h0, 1'b1);
        check("alias_read", rdata_o[0], 32'h12345678);

        // Reset during the wait states of a store drops it
        do_req(0, 1'b0, 1'b1, 32'h40, 32'h55555555, 1'b0);
        @(negedge clk);
        rd_v[0] = 1'b0; wr_v[0] = 1'b1; ad_v[0] = 32'h40; wd_v[0] = 32'hAAAAAAAA;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready_o[0]), 32'd0);
        check("midrst_busy", 32'(busy_o[0]), 32'd0);
        check("midrst_err", 32'(err_o[0]), 32'd0);
        check("midrst_rdata", rdata_o[0], 32'd0);
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        wr_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("midrst_no_ready", 32'(ready_o[0]), 32'd0);
        end
        do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        check("midrst_old_data", rdata_o[0], 32'h55555555);

        do_req(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0);
        do_req(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        check("zw_read", rdata_o[1], 32'hCAFEF00D);

        // Random mix of legal/illegal loads and stores with aliased addresses
        for (int n = 0; n < 60; n++) begin
            s  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 5));
            a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if (op == 5) a = a | 32'($urandom_range(1, 3));
            do_req(s, (op < 2) || (op >= 4), (op == 2) || (op == 3) || (op == 4),
                   a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
